// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator interface and the SAR search FSM.
package cmp_pkg;

  // Comparator result codes: target a versus probe b.
  localparam logic [1:0] CMP_INV = 2'b00;
  localparam logic [1:0] CMP_GT  = 2'b01;  // a > b
  localparam logic [1:0] CMP_LT  = 2'b10;  // a < b
  localparam logic [1:0] CMP_EQ  = 2'b11;  // a == b

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_FIN    = 2'd3
  } sar_state_e;

endpackage

// File: rtl/Compare_4bit.sv
// 4-bit magnitude comparator producing the two-bit result code (a vs b).
module Compare_4bit
  import cmp_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [1:0] cmp_code
);

  // Pure combinational compare; never produces CMP_INV.
  always_comb begin
    cmp_code = CMP_EQ;
    if (a > b)      cmp_code = CMP_GT;
    else if (a < b) cmp_code = CMP_LT;
  end

endmodule

// File: rtl/cmp_sar_search.sv
// Successive-approximation search: drives a probe into a comparator and
// recovers the unknown target one bit per decision, MSB first.
module cmp_sar_search
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       cmp_code,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sar_state_e       state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] probe_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             settle_last;
  logic [WIDTH-1:0] probe_upd;
  logic [WIDTH-1:0] probe_nxt;

  // Apply the current decision to bit k, then arm the next lower bit.
  always_comb begin
    probe_upd = probe_q;
    if (cmp_code == CMP_LT) probe_upd[k_q] = 1'b0;
    probe_nxt = probe_upd;
    if (k_q != '0) probe_nxt[k_q - 1'b1] = 1'b1;
  end

  // Settle counter exists only when the comparator needs extra cycles.
  generate
    if (SETTLE > 0) begin : g_settle
      localparam int CW = $clog2(SETTLE + 1);
      logic [CW-1:0] settle_q;
      logic          settle_load;

      assign settle_load = (state_q == ST_IDLE && start) ||
                           (state_q == ST_DECIDE && k_q != '0 &&
                            (cmp_code == CMP_GT || cmp_code == CMP_LT));

      // Reload on every probe update, count down while waiting.
      always_ff @(posedge clk) begin
        if (rst) begin
          settle_q <= '0;
        end else if (settle_load) begin
          settle_q <= CW'(SETTLE);
        end else if (state_q == ST_WAIT && settle_q != '0) begin
          settle_q <= settle_q - 1'b1;
        end
      end

      assign settle_last = (settle_q == CW'(1));
    end else begin : g_no_settle
      assign settle_last = 1'b1;
    end
  endgenerate

  // Search FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      probe_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            probe_q          <= '0;
            probe_q[WIDTH-1] <= 1'b1;
            k_q              <= KW'(WIDTH - 1);
            busy_q           <= 1'b1;
            state_q          <= (SETTLE > 0) ? ST_WAIT : ST_DECIDE;
          end
        end
        ST_WAIT: begin
          if (settle_last) state_q <= ST_DECIDE;
        end
        ST_DECIDE: begin
          case (cmp_code)
            CMP_EQ: begin
              result_q <= probe_q;
              err_q    <= 1'b0;
              state_q  <= ST_FIN;
            end
            CMP_INV: begin
              result_q <= probe_q;
              err_q    <= 1'b1;
              state_q  <= ST_FIN;
            end
            default: begin
              if (k_q == '0) begin
                probe_q  <= probe_upd;
                result_q <= probe_upd;
                err_q    <= 1'b0;
                state_q  <= ST_FIN;
              end else begin
                probe_q <= probe_nxt;
                k_q     <= k_q - 1'b1;
                state_q <= (SETTLE > 0) ? ST_WAIT : ST_DECIDE;
              end
            end
          endcase
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign probe  = probe_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_cmp_sar_search.sv
// Closed-loop bench: two searchers (SETTLE=0 and SETTLE=2), each probing a
// Compare_4bit whose a input holds the target. Expected completions are queued
// at start; monitors pop and check on every done pulse.
module tb_cmp_sar_search;
  import cmp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1, force0;
  logic [3:0] tgt0, tgt1;
  logic [1:0] cmp_raw0, cmp_raw1, cmp0;
  logic [3:0] probe0, probe1, result0, result1;
  logic       busy0, busy1, done0, done1, err0, err1;

  // An invalid code can be injected on dut0's comparator path.
  assign cmp0 = force0 ? CMP_INV : cmp_raw0;

  Compare_4bit u_cmp0 (.a(tgt0), .b(probe0), .cmp_code(cmp_raw0));
  Compare_4bit u_cmp1 (.a(tgt1), .b(probe1), .cmp_code(cmp_raw1));

  cmp_sar_search #(.WIDTH(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .cmp_code(cmp0),
    .probe(probe0), .busy(busy0), .done(done0), .result(result0), .err(err0)
  );

  cmp_sar_search #(.WIDTH(4), .SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cmp_code(cmp_raw1),
    .probe(probe1), .busy(busy1), .done(done1), .result(result1), .err(err1)
  );

  typedef struct {
    logic [3:0] res;
    logic       err;
    int         at;
    string      name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for dut0: every done pulse must match the oldest expectation.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        check("dut0 unexpected done", 32'(done0), 32'd0);
      end else begin
        e = q0.pop_front();
        check({e.name, " result"}, 32'(result0), 32'(e.res));
        check({e.name, " err"}, 32'(err0), 32'(e.err));
        check({e.name, " done cycle"}, 32'(cyc), 32'(e.at));
        $display("[TB] %s: done at cycle %0d result=%b err=%b", e.name, cyc, result0, err0);
      end
    end
  end

  // Monitor for dut1.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected done", 32'(done1), 32'd0);
      end else begin
        e = q1.pop_front();
        check({e.name, " result"}, 32'(result1), 32'(e.res));
        check({e.name, " err"}, 32'(err1), 32'(e.err));
        check({e.name, " done cycle"}, 32'(cyc), 32'(e.at));
        $display("[TB] %s: done at cycle %0d result=%b err=%b", e.name, cyc, result1, err1);
      end
    end
  end

  // Called at a negedge: pulse start for one edge and queue the expectation.
  // Returns at the negedge just after the accepting edge, when cyc == c0;
  // done is expected to be visible lat edges later.
  task automatic issue(input int which, input logic [3:0] t, input logic [3:0] r,
                       input logic e, input int lat, input string name);
    exp_t x;
    if (which == 0) begin
      tgt0 = t; start0 = 1'b1;
    end else begin
      tgt1 = t; start1 = 1'b1;
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    x.res = r; x.err = e; x.at = cyc + lat; x.name = name;
    if (which == 0) q0.push_back(x);
    else            q1.push_back(x);
  endtask

  // Bounded wait; returns at the negedge where done is seen.
  task automatic wait_done(input int which, input int budget, input string name);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (which == 0 && done0 === 1'b1) seen = 1;
      if (which == 1 && done1 === 1'b1) seen = 1;
    end
    check({name, " done within budget"}, 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; force0 = 1'b0;
    tgt0 = 4'd0; tgt1 = 4'd0;
    repeat (3) @(negedge clk);
    check("reset busy0",   32'(busy0),   32'd0);
    check("reset done0",   32'(done0),   32'd0);
    check("reset probe0",  32'(probe0),  32'd0);
    check("reset result0", 32'(result0), 32'd0);
    check("reset err0",    32'(err0),    32'd0);
    check("reset probe1",  32'(probe1),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Target 1011: three bit decisions then equality on the 4th probe.
    issue(0, 4'b1011, 4'b1011, 1'b0, 5, "t1011");
    check("t1011 busy after start", 32'(busy0), 32'd1);
    check("t1011 probe0", 32'(probe0), 32'b1000);
    @(negedge clk); check("t1011 probe1", 32'(probe0), 32'b1100);
    @(negedge clk); check("t1011 probe2", 32'(probe0), 32'b1010);
    @(negedge clk); check("t1011 probe3", 32'(probe0), 32'b1011);
    wait_done(0, 20, "t1011");
    @(negedge clk);
    check("t1011 busy after done", 32'(busy0), 32'd0);
    check("t1011 done is one pulse", 32'(done0), 32'd0);

    // Target 0000 with a second start while busy (must be dropped).
    issue(0, 4'b0000, 4'b0000, 1'b0, 5, "t0000");
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("t0000 probe after 1st decision", 32'(probe0), 32'b0100);
    wait_done(0, 20, "t0000");

    // Back-to-back: start in the cycle done is high; early equality.
    issue(0, 4'b1000, 4'b1000, 1'b0, 2, "t1000");
    wait_done(0, 20, "t1000");
    repeat (6) @(negedge clk);

    // SETTLE=2: each probe held 3 cycles, equality on the 4th probe.
    issue(1, 4'b1111, 4'b1111, 1'b0, 13, "t1111s2");
    check("t1111s2 probe c0", 32'(probe1), 32'b1000);
    @(negedge clk); check("t1111s2 probe c1", 32'(probe1), 32'b1000);
    @(negedge clk); check("t1111s2 probe c2", 32'(probe1), 32'b1000);
    @(negedge clk); check("t1111s2 probe c3", 32'(probe1), 32'b1100);
    wait_done(1, 30, "t1111s2");

    // Invalid code on the second decision.
    issue(0, 4'b1011, 4'b1100, 1'b1, 3, "tinv");
    @(negedge clk);
    force0 = 1'b1;
    @(negedge clk);
    force0 = 1'b0;
    wait_done(0, 20, "tinv");
    repeat (2) @(negedge clk);
    check("tinv err holds",    32'(err0),    32'd1);
    check("tinv result holds", 32'(result0), 32'b1100);

    // Reset after two decisions aborts with no done.
    issue(0, 4'b0110, 4'b0110, 1'b0, 4, "tabort");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    check("abort busy",   32'(busy0),   32'd0);
    check("abort probe",  32'(probe0),  32'd0);
    check("abort result", 32'(result0), 32'd0);
    check("abort err",    32'(err0),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(0, 4'b0110, 4'b0110, 1'b0, 4, "t0110");
    wait_done(0, 20, "t0110");
    repeat (6) @(negedge clk);

    check("dut0 pending expectations", 32'(q0.size()), 32'd0);
    check("dut1 pending expectations", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
